// File: rtl/output_logic.sv
// Per-channel egress: drains committed packets from a show-ahead FIFO onto a req/ack byte port.
// 1-cycle pop-to-req latency, 1 byte/cycle throughput; stalls (fifo_pop=0) while req is held without ack.
module output_logic #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic                  crc_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_req,
    input  logic                  data_out_ack,
    output logic                  data_out_last,
    output logic                  busy,
    output logic                  pkt_done
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC} state_t;

    state_t                  state_q, state_d;
    logic [DATA_SIZE-1:0]    rem_q, rem_d;
    logic                    crc_flag_q, crc_flag_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    req_q, req_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    free;
    logic                    xfer_last;
    logic                    last_pop;
    logic [DATA_SIZE-1:0]    hdr_len;

    always_comb begin
        free       = !req_q || data_out_ack;
        fifo_pop   = free && !fifo_empty && rst_n;
        hdr_len    = fifo_data_out[DATA_SIZE-1:0];
        xfer_last  = req_q && data_out_ack && last_q;

        state_d    = state_q;
        rem_d      = rem_q;
        crc_flag_d = crc_flag_q;
        data_d     = data_q;
        req_d      = req_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = xfer_last;
        last_pop   = 1'b0;

        if (xfer_last) begin
            busy_d = 1'b0;
        end

        if (fifo_pop) begin
            data_d = fifo_data_out;
            req_d  = 1'b1;
            case (state_q)
                IDLE: begin
                    crc_flag_d = crc_en;
                    rem_d      = hdr_len;
                    busy_d     = 1'b1;
                    if (hdr_len != '0) begin
                        state_d = PAYLOAD;
                    end else if (crc_en) begin
                        state_d = CRC;
                    end else begin
                        last_pop = 1'b1;
                    end
                end
                PAYLOAD: begin
                    // Guarded decrement: the counter never wraps below zero.
                    if (rem_q != '0) begin
                        rem_d = rem_q - DATA_SIZE'(1);
                    end
                    if (rem_q <= DATA_SIZE'(1)) begin
                        if (crc_flag_q) begin
                            state_d = CRC;
                        end else begin
                            state_d  = IDLE;
                            last_pop = 1'b1;
                        end
                    end
                end
                CRC: begin
                    state_d  = IDLE;
                    last_pop = 1'b1;
                end
                default: state_d = IDLE;
            endcase
            last_d = last_pop;
        end else if (free) begin
            req_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            crc_flag_q <= 1'b0;
            data_q     <= '0;
            req_q      <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            crc_flag_q <= crc_flag_d;
            data_q     <= data_d;
            req_q      <= req_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_out      = data_q;
    assign data_out_req  = req_q;
    assign data_out_last = last_q;
    assign busy          = busy_q;
    assign pkt_done      = done_q;

endmodule

// File: tb/tb_output_logic.sv
// Bench for output_logic: a behavioural show-ahead FIFO feeds the DUT; per-cycle vector table plus a
// hand-written asynchronous-reset sequence.
module tb_output_logic;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fifo_data_out;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       crc_en = 1'b0;
    logic [7:0] data_out;
    logic       data_out_req;
    logic       data_out_ack = 1'b1;
    logic       data_out_last;
    logic       busy;
    logic       pkt_done;

    logic [7:0] mem [0:255];
    int         wr = 0;
    int         rd = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        string      nm;
        logic       ack;
        logic       crc;
        logic       pe;
        logic [7:0] pb;
        logic       pop;
        logic       req;
        logic [7:0] d;
        logic       last;
        logic       bsy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    output_logic #(.DATA_WIDTH(8), .DATA_SIZE(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .crc_en        (crc_en),
        .data_out      (data_out),
        .data_out_req  (data_out_req),
        .data_out_ack  (data_out_ack),
        .data_out_last (data_out_last),
        .busy          (busy),
        .pkt_done      (pkt_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty    = (rd == wr);
    assign fifo_data_out = mem[rd[7:0]];

    always @(posedge clk) begin
        if (fifo_pop) rd <= rd + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wr[7:0]] = b;
        wr++;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic pop, input logic req, input logic [7:0] d,
                              input logic last, input logic bsy, input logic done);
        chk({nm, ".pop"},  fifo_pop,      pop);
        chk({nm, ".req"},  data_out_req,  req);
        chk({nm, ".data"}, data_out,      d);
        chk({nm, ".last"}, data_out_last, last);
        chk({nm, ".busy"}, busy,          bsy);
        chk({nm, ".done"}, pkt_done,      done);
    endtask

    task automatic cyc(input logic ack, input logic crc, input logic pe, input logic [7:0] pb);
        @(posedge clk);
        #1;
        data_out_ack = ack;
        crc_en       = crc;
        if (pe) push(pb);
        @(negedge clk);
    endtask

    function automatic void add(input string nm, input logic ack, input logic crc, input logic pe,
                                input logic [7:0] pb, input logic pop, input logic req, input logic [7:0] d,
                                input logic last, input logic bsy, input logic done);
        vec_t v;
        v.nm = nm; v.ack = ack; v.crc = crc; v.pe = pe; v.pb = pb;
        v.pop = pop; v.req = req; v.d = d; v.last = last; v.bsy = bsy; v.done = done;
        vecs.push_back(v);
    endfunction

    initial begin
        //   name  ack crc pe  push   pop req data   last busy done
        add("t1", 1, 0, 1, 8'h43,  1, 0, 8'h00, 0, 0, 0);
        add("t1", 1, 0, 1, 8'hA1,  1, 1, 8'h43, 0, 1, 0);
        add("t1", 1, 0, 1, 8'hA2,  1, 1, 8'hA1, 0, 1, 0);
        add("t1", 1, 0, 1, 8'hA3,  1, 1, 8'hA2, 0, 1, 0);
        add("t1", 1, 0, 0, 8'h00,  0, 1, 8'hA3, 1, 1, 0);
        add("t1", 1, 0, 0, 8'h00,  0, 0, 8'hA3, 0, 0, 1);
        add("t1", 1, 0, 0, 8'h00,  0, 0, 8'hA3, 0, 0, 0);
        // crc_en drops right after the header pop; framing must still include the CRC byte
        add("t2", 1, 1, 1, 8'h82,  1, 0, 8'hA3, 0, 0, 0);
        add("t2", 1, 0, 1, 8'h11,  1, 1, 8'h82, 0, 1, 0);
        add("t2", 1, 0, 1, 8'h22,  1, 1, 8'h11, 0, 1, 0);
        add("t2", 1, 0, 1, 8'h5C,  1, 1, 8'h22, 0, 1, 0);
        add("t2", 1, 0, 0, 8'h00,  0, 1, 8'h5C, 1, 1, 0);
        add("t2", 1, 0, 0, 8'h00,  0, 0, 8'h5C, 0, 0, 1);
        add("t3", 1, 0, 1, 8'h00,  1, 0, 8'h5C, 0, 0, 0);
        add("t3", 1, 0, 1, 8'hC0,  1, 1, 8'h00, 1, 1, 0);
        add("t3", 1, 0, 0, 8'h00,  0, 1, 8'hC0, 1, 1, 1);
        add("t3", 1, 0, 0, 8'h00,  0, 0, 8'hC0, 0, 0, 1);
        add("t3", 1, 0, 0, 8'h00,  0, 0, 8'hC0, 0, 0, 0);
        add("t4", 1, 0, 1, 8'h42,  1, 0, 8'hC0, 0, 0, 0);
        add("t4", 0, 0, 1, 8'h10,  0, 1, 8'h42, 0, 1, 0);
        add("t4", 0, 0, 1, 8'h20,  0, 1, 8'h42, 0, 1, 0);
        add("t4", 0, 0, 0, 8'h00,  0, 1, 8'h42, 0, 1, 0);
        add("t4", 1, 0, 0, 8'h00,  1, 1, 8'h42, 0, 1, 0);
        add("t4", 1, 0, 0, 8'h00,  1, 1, 8'h10, 0, 1, 0);
        add("t4", 1, 0, 0, 8'h00,  0, 1, 8'h20, 1, 1, 0);
        add("t4", 1, 0, 0, 8'h00,  0, 0, 8'h20, 0, 0, 1);
        add("t5", 1, 0, 1, 8'h03,  1, 0, 8'h20, 0, 0, 0);
        add("t5", 1, 0, 1, 8'hB1,  1, 1, 8'h03, 0, 1, 0);
        add("t5", 1, 0, 0, 8'h00,  0, 1, 8'hB1, 0, 1, 0);
        add("t5", 1, 0, 0, 8'h00,  0, 0, 8'hB1, 0, 1, 0);
        add("t5", 1, 0, 0, 8'h00,  0, 0, 8'hB1, 0, 1, 0);
        add("t5", 1, 0, 0, 8'h00,  0, 0, 8'hB1, 0, 1, 0);
        add("t5", 1, 0, 1, 8'hB2,  1, 0, 8'hB1, 0, 1, 0);
        add("t5", 1, 0, 1, 8'hB3,  1, 1, 8'hB2, 0, 1, 0);
        add("t5", 1, 0, 0, 8'h00,  0, 1, 8'hB3, 1, 1, 0);
        add("t5", 1, 0, 0, 8'h00,  0, 0, 8'hB3, 0, 0, 1);
        add("t5", 1, 0, 0, 8'h00,  0, 0, 8'hB3, 0, 0, 0);

        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].ack, vecs[i].crc, vecs[i].pe, vecs[i].pb);
            check_outs($sformatf("%s[%0d]", vecs[i].nm, i), vecs[i].pop, vecs[i].req, vecs[i].d,
                       vecs[i].last, vecs[i].bsy, vecs[i].done);
        end

        // Asynchronous reset inside a 0x05 packet, then a fresh 1-byte packet
        cyc(1, 0, 1, 8'h05); check_outs("rst_a", 1, 0, 8'hB3, 0, 0, 0);
        cyc(1, 0, 1, 8'h51); check_outs("rst_b", 1, 1, 8'h05, 0, 1, 0);
        cyc(1, 0, 0, 8'h00); check_outs("rst_c", 0, 1, 8'h51, 0, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 0, 0, 8'h00, 0, 0, 0);
        push(8'h01);
        #1;
        chk("rst_pop_gate", fifo_pop, 1'b0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_outs("rst_hold", 0, 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_pop", fifo_pop, 1'b1);
        cyc(1, 0, 1, 8'h77); check_outs("post_hdr",  1, 1, 8'h01, 0, 1, 0);
        cyc(1, 0, 0, 8'h00); check_outs("post_last", 0, 1, 8'h77, 1, 1, 0);
        cyc(1, 0, 0, 8'h00); check_outs("post_done", 0, 0, 8'h77, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/output_logic.md
Name: output_logic

Overview:
- Per-channel egress stage of the router. One instance sits downstream of each channel's fifo_synch.
- Drains committed packets from the show-ahead FIFO and presents them byte by byte on the channel's output port, using a req/ack handshake.
- Parses the header byte to find the packet boundary, so it can flag the end of each packet and track per-packet state.

Parameters:
- DATA_WIDTH, 8, byte width of FIFO data and output data.
- DATA_SIZE, 6, width of the header length field; maximum payload is 2^DATA_SIZE-1 bytes.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_data_out  input  DATA_WIDTH  FIFO head byte; show-ahead, valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO has no committed bytes.
- fifo_pop  output  1  combinational; advances the FIFO read pointer this cycle.
- crc_en  input  1  from config_regs; when 1, each packet carries a trailing CRC byte.
- data_out  output  DATA_WIDTH  registered output byte.
- data_out_req  output  1  registered; data_out is valid.
- data_out_ack  input  1  sink accepts the byte when sampled high together with req.
- data_out_last  output  1  registered; the current data_out is the final byte of the packet.
- busy  output  1  registered; a packet is in progress (header popped, last byte not yet accepted).
- pkt_done  output  1  registered one-cycle pulse; the last byte of a packet was accepted.

Behaviour:
- Reset (async, rst_n=0):
  - data_out=0, data_out_req=0, data_out_last=0, busy=0, pkt_done=0.
  - State=IDLE, byte counter=0, latched CRC flag=0.
  - fifo_pop=0 while in reset.
- Packet format:
  - Byte 0 is the header: [7:6] destination address (forwarded unchanged), [DATA_SIZE-1:0] payload length L (0..63).
  - Then L payload bytes.
  - Then 1 CRC byte if the latched CRC flag is set.
  - Total length is 1 + L + crc bytes.
- Output register free condition: free = !data_out_req || data_out_ack.
- Pop rule:
  - fifo_pop = free && !fifo_empty, combinational.
  - When fifo_pop=1, at the next edge: data_out<=fifo_data_out, data_out_req<=1, data_out_last<=computed last.
  - When free && fifo_empty: data_out_req<=0 and data_out keeps its value.
- Handshake:
  - data_out and data_out_last hold stable while req=1 and ack=0.
  - A transfer happens on a cycle with req&&ack.
  - Back-to-back throughput is 1 byte/cycle (ack and a reload occur in the same cycle).
- Latency: fifo_empty falling at cycle N gives data_out_req=1 at cycle N+1.
- FSM (advances on fifo_pop):
  - IDLE: the popped byte is a header.
    - Latch crc_flag<=crc_en and rem<=L.
    - Next state: PAYLOAD if L>0; else CRC if crc_en; else IDLE with last=1.
    - busy<=1.
  - PAYLOAD: rem<=rem-1. When rem==1, go to CRC if crc_flag (last=0), else go to IDLE with last=1.
  - CRC: pop the CRC byte with last=1, then go to IDLE.
- crc_en is sampled only at header pop. A mid-packet change has no effect on the current packet.
- pkt_done:
  - pkt_done<=1 on the edge after a cycle with req&&ack&&data_out_last.
  - busy<=0 on that same edge unless a new header is popped in that cycle, in which case busy stays 1.
- The rem counter is DATA_SIZE bits wide. It must not wrap: a decrement happens only in PAYLOAD with rem>=1.
- Mid-packet underflow (fifo_empty=1 inside a packet):
  - The FSM holds state and counter; req drops once the current byte is accepted.
  - When data arrives, the packet resumes without error.
- Reset mid-packet aborts immediately to the reset values. FIFO contents are the FIFO's responsibility (it is reset in parallel).

Test Plan:
- Single packet, crc_en=0:
  - Stimulus: FIFO holds 0x43,0xA1,0xA2,0xA3; ack tied 1.
  - Expected: fifo_empty low at cycle 0 → req=1 at cycles 1..4 with data 0x43,0xA1,0xA2,0xA3.
  - data_out_last=1 only with 0xA3; pkt_done=1 at cycle 5; busy 1→0 at cycle 5.
- Packet with CRC:
  - Stimulus: crc_en=1, bytes 0x82,0x11,0x22,0x5C.
  - Expected: 4 transfers, last=1 only on 0x5C; crc_en toggled to 0 after the header pop does not change the framing.
- Zero-length packets back-to-back:
  - Stimulus: crc_en=0, headers 0x00 then 0xC0, ack=1.
  - Expected: two transfers on consecutive cycles, each with last=1; pkt_done pulses on two consecutive cycles; fifo_pop high 2 consecutive cycles.
- Backpressure:
  - Stimulus: header 0x42, payload 0x10,0x20; ack low for 3 cycles after the first req.
  - Expected: data_out holds 0x42 and fifo_pop=0 during the stall; after ack, all bytes are delivered in order with no duplication or loss.
- Underflow mid-packet:
  - Stimulus: header 0x03 and 1 payload byte available, then fifo_empty=1 for 4 cycles, then 2 more bytes.
  - Expected: req drops during the gap; last=1 only on the 3rd payload byte; exactly one pkt_done.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 asynchronously (mid-cycle) after 2 bytes of a 0x05 packet.
  - Expected: outputs go to 0 immediately without waiting for a clock; after release, the next byte is treated as a header.
